// File: rtl/vctr_sq_acc.sv
// Streams signed elements from an upstream FIFO and accumulates their squares.
// Define HM_SQ_ACC_DIV_EN to divide the sum by the length, giving the mean square.
module vctr_sq_acc #(
  parameter int DATA_WIDTH  = 16,
  parameter int LENGTH_BITS = 8,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + LENGTH_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_empty,
  output logic                   data_in_rd_en,
  input  logic [LENGTH_BITS-1:0] vector_length,
  input  logic                   start,
  output logic [ACC_WIDTH-1:0]   result,
  output logic                   done,
  output logic                   idle,
  output logic                   ready
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
`ifdef HM_SQ_ACC_DIV_EN
    S_DIVIDE  = 2'd2,
`endif
    S_DONE    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [LENGTH_BITS-1:0]   len_q, len_d;
  logic [LENGTH_BITS-1:0]   issued_q, issued_d;
  logic [LENGTH_BITS-1:0]   received_q, received_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic                     rd_vld_q, rd_vld_d;
  logic                     data_vld_q, data_vld_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ACC_WIDTH-1:0]     result_q, result_d;
  logic                     done_q, done_d;
  logic                     idle_q, idle_d;
  logic [2*DATA_WIDTH-1:0]  ext_s;
  logic [2*DATA_WIDTH-1:0]  sq_s;

`ifdef HM_SQ_ACC_DIV_EN
  localparam int CNT_W = $clog2(ACC_WIDTH + 1);
  logic [ACC_WIDTH-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]         div_cnt_q, div_cnt_d;
  logic [ACC_WIDTH:0]       rem_shift_s;
  logic [ACC_WIDTH:0]       divisor_s;
  // Restoring divider: acc_q doubles as the dividend/quotient shift register.
  assign rem_shift_s = {rem_q, acc_q[ACC_WIDTH-1]};
  assign divisor_s   = {{(ACC_WIDTH+1-LENGTH_BITS){1'b0}}, len_q};
`endif

  assign data_in_rd_en = (state_q == S_COMPUTE) && !data_in_empty && (issued_q < len_q);
  // Sign-extended square; the true square is non-negative so the low bits are exact.
  assign ext_s = {{DATA_WIDTH{data_q[DATA_WIDTH-1]}}, data_q};
  assign sq_s  = ext_s * ext_s;
  assign result = result_q;
  assign done   = done_q;
  assign idle   = idle_q;
  assign ready  = idle_q;

  // Next-state, pipeline and datapath logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    acc_d      = acc_q;
    result_d   = result_q;
    rd_vld_d   = data_in_rd_en;
    data_vld_d = rd_vld_q;
    data_d     = data_q;
`ifdef HM_SQ_ACC_DIV_EN
    rem_d      = rem_q;
    div_cnt_d  = div_cnt_q;
`endif
    if (rd_vld_q) begin
      data_d = data_in;
    end else begin
      data_d = data_q;
    end
    if (data_vld_q) begin
      acc_d      = acc_q + ACC_WIDTH'(sq_s);
      received_d = received_q + LENGTH_BITS'(1);
    end else begin
      acc_d      = acc_q;
      received_d = received_q;
    end
    if (data_in_rd_en) begin
      issued_d = issued_q + LENGTH_BITS'(1);
    end else begin
      issued_d = issued_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = vector_length;
          acc_d      = '0;
          issued_d   = '0;
          received_d = '0;
          if (vector_length == '0) begin
            state_d  = S_DONE;
            result_d = '0;
          end else begin
            state_d  = S_COMPUTE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        if (received_q == len_q) begin
`ifdef HM_SQ_ACC_DIV_EN
          state_d   = S_DIVIDE;
          rem_d     = '0;
          div_cnt_d = '0;
`else
          state_d   = S_DONE;
          result_d  = acc_q;
`endif
        end else begin
          state_d = S_COMPUTE;
        end
      end
`ifdef HM_SQ_ACC_DIV_EN
      S_DIVIDE: begin
        if (rem_shift_s >= divisor_s) begin
          rem_d = ACC_WIDTH'(rem_shift_s - divisor_s);
          acc_d = {acc_q[ACC_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = ACC_WIDTH'(rem_shift_s);
          acc_d = {acc_q[ACC_WIDTH-2:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (div_cnt_q == CNT_W'(ACC_WIDTH-1)) begin
          state_d  = S_DONE;
          result_d = acc_d;
        end else begin
          state_d  = S_DIVIDE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    idle_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      acc_q      <= '0;
      rd_vld_q   <= 1'b0;
      data_vld_q <= 1'b0;
      data_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
`ifdef HM_SQ_ACC_DIV_EN
      rem_q      <= '0;
      div_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      acc_q      <= acc_d;
      rd_vld_q   <= rd_vld_d;
      data_vld_q <= data_vld_d;
      data_q     <= data_d;
      result_q   <= result_d;
      done_q     <= done_d;
      idle_q     <= idle_d;
`ifdef HM_SQ_ACC_DIV_EN
      rem_q      <= rem_d;
      div_cnt_q  <= div_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_vctr_sq_acc.sv
// Scoreboard bench for vctr_sq_acc: stimulus pushes expected results, a monitor
// checks them on every done pulse. Expectations follow HM_SQ_ACC_DIV_EN.
module tb_vctr_sq_acc;
  localparam int DW = 16;
  localparam int LB = 8;
  localparam int AW = 2*DW + LB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_empty = 1'b1;
  logic          data_in_rd_en;
  logic [LB-1:0] vector_length = '0;
  logic          start = 1'b0;
  logic [AW-1:0] result;
  logic          done, idle, ready;

  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] fifo[$];
  bit            stall = 1'b0;
  int            rd_count = 0;
  int            viol = 0;
  int            done_count = 0;
  logic          prev_done = 1'b0;

  vctr_sq_acc #(.DATA_WIDTH(DW), .LENGTH_BITS(LB), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_empty(data_in_empty),
    .data_in_rd_en(data_in_rd_en), .vector_length(vector_length), .start(start),
    .result(result), .done(done), .idle(idle), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ex(input logic [AW-1:0] raw, input logic [AW-1:0] dv);
`ifdef HM_SQ_ACC_DIV_EN
    return dv;
`else
    return raw;
`endif
  endfunction

  // Upstream FIFO model: data appears the cycle after a pop request.
  always @(posedge clk) begin
    if (data_in_rd_en === 1'b1) begin
      if (data_in_empty || fifo.size() == 0) viol++;
      else data_in <= fifo.pop_front();
      rd_count++;
    end
  end

  always @(negedge clk) data_in_empty = stall || (fifo.size() == 0);

  // Monitor: compare every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      check("done_pulse", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("result", result, exp_q.pop_front());
    end
    prev_done = done;
  end

  task automatic start_op(input int len);
    @(posedge clk); #1;
    vector_length = LB'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int target;
    target = done_count + 1;
    for (int i = 0; i < budget && done_count < target; i++) @(posedge clk);
    check(name, {63'd0, done_count >= target}, 64'd1);
  endtask

  task automatic wait_rd(input string name, input int base, input int n, input int budget);
    for (int i = 0; i < budget && (rd_count - base) < n; i++) @(negedge clk);
    check(name, {63'd0, (rd_count - base) >= n}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, result, 64'd0);
    check({tag, "_done"},   {63'd0, done}, 64'd0);
    check({tag, "_rd_en"},  {63'd0, data_in_rd_en}, 64'd0);
    check({tag, "_idle"},   {63'd0, idle}, 64'd1);
    check({tag, "_ready"},  {63'd0, ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, dc0, fsize;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // Elements 1..8 back-to-back.
    for (int i = 1; i <= 8; i++) fifo.push_back(DW'(i));
    rd0 = rd_count; viol = 0;
    exp_q.push_back(ex(AW'(204), AW'(25)));
    start_op(8);
    wait_done("t030_timeout", 300);
    check("t030_reads", rd_count - rd0, 64'd8);

    // Negative element.
    fifo.push_back(16'hFFFD); fifo.push_back(16'h0004);
    rd0 = rd_count;
    exp_q.push_back(ex(AW'(25), AW'(12)));
    start_op(2);
    wait_done("t031_timeout", 300);
    check("t031_reads", rd_count - rd0, 64'd2);

    // Zero length: done one cycle after accept, no reads.
    rd0 = rd_count; dc0 = done_count;
    exp_q.push_back(AW'(0));
    @(posedge clk); #1; vector_length = '0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("t032_done_latency", {63'd0, done}, 64'd1);
    repeat (3) @(posedge clk);
    check("t032_done_count", done_count - dc0, 64'd1);
    check("t032_reads", rd_count - rd0, 64'd0);

    // Upstream runs empty for 5 cycles mid-vector.
    fifo.push_back(DW'(2)); fifo.push_back(DW'(2));
    rd0 = rd_count; viol = 0;
    exp_q.push_back(ex(AW'(16), AW'(4)));
    start_op(4);
    wait_rd("t033_first_two", rd0, 2, 50);
    stall = 1'b1;
    fifo.push_back(DW'(2)); fifo.push_back(DW'(2));
    repeat (5) @(negedge clk);
    check("t033_stall_reads", rd_count - rd0, 64'd2);
    stall = 1'b0;
    wait_done("t033_timeout", 300);
    check("t033_reads", rd_count - rd0, 64'd4);
    check("t033_empty_reads", viol, 64'd0);

    // Most negative element; a start while busy must be ignored.
    fifo.push_back(16'h8000);
    rd0 = rd_count; dc0 = done_count;
    exp_q.push_back(AW'(32'h4000_0000));
    start_op(1);
    @(posedge clk); #1; vector_length = LB'(5); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("t034_timeout", 300);
    repeat (10) @(posedge clk);
    check("t034_busy_start_ignored", done_count - dc0, 64'd1);
    check("t034_reads", rd_count - rd0, 64'd1);
    check("t034_idle", {63'd0, idle}, 64'd1);

    // Reset after 3 of 8 elements, then a fresh length-1 operation.
    for (int i = 1; i <= 8; i++) fifo.push_back(DW'(i));
    rd0 = rd_count;
    start_op(8);
    wait_rd("t035_three_reads", rd0, 3, 50);
    rst_n = 1'b0;
    #1 check_reset_outputs("t035_reset");
    fsize = fifo.size();
    repeat (3) @(posedge clk);
    check("t035_no_consume", fifo.size(), 64'(fsize));
    fifo.delete();
    #1 rst_n = 1'b1;
    fifo.push_back(DW'(3));
    rd0 = rd_count;
    exp_q.push_back(ex(AW'(9), AW'(9)));
    start_op(1);
    wait_done("t035_timeout", 300);
    check("t035_reads", rd_count - rd0, 64'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
